// File: rtl/sc_fifo.sv
// ---------------------------------------------------------------------------
// sc_fifo -- single-clock synchronous FIFO with registered read data and
// registered occupancy flags.
//
// Parameters
//   DWIDTH             data word width
//   AWIDTH             address width, depth is 2**AWIDTH words
//   ALMOST_FULL_VALUE  almost_full_o asserted when usedw_o >= this value
//   ALMOST_EMPTY_VALUE almost_empty_o asserted when usedw_o < this value
//
// Ports
//   clk_i          clock, all state updates on rising edge
//   rst_i          asynchronous active-high reset
//   wrreq_i        write request, pushes data_i when not full
//   data_i         write data
//   rdreq_i        read request, pops oldest word when not empty
//   q_o            read data, valid the cycle after an accepted read
//   empty_o        no words stored
//   full_o         DEPTH words stored
//   usedw_o        number of stored words (0..DEPTH)
//   almost_full_o  usedw_o >= ALMOST_FULL_VALUE
//   almost_empty_o usedw_o <  ALMOST_EMPTY_VALUE
// ---------------------------------------------------------------------------
module sc_fifo #(
   parameter int DWIDTH             = 16,
   parameter int AWIDTH             = 4,
   parameter int ALMOST_FULL_VALUE  = 12,
   parameter int ALMOST_EMPTY_VALUE = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wrreq_i,
   input  logic [DWIDTH-1:0] data_i,
   input  logic              rdreq_i,
   output logic [DWIDTH-1:0] q_o,
   output logic              empty_o,
   output logic              full_o,
   output logic [AWIDTH:0]   usedw_o,
   output logic              almost_full_o,
   output logic              almost_empty_o
);

   localparam int              DEPTH     = 2 ** AWIDTH;
   localparam logic [AWIDTH:0] DEPTH_CNT = (AWIDTH + 1)'(DEPTH);
   localparam logic [AWIDTH:0] AF_LVL    = (AWIDTH + 1)'(ALMOST_FULL_VALUE);
   localparam logic [AWIDTH:0] AE_LVL    = (AWIDTH + 1)'(ALMOST_EMPTY_VALUE);
   localparam logic [AWIDTH:0] CNT_ONE   = (AWIDTH + 1)'(1);
   localparam logic [AWIDTH:0] CNT_ZERO  = (AWIDTH + 1)'(0);
   localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1);

   // Storage is intentionally not reset; it is only observable after being rewritten.
   logic [DWIDTH-1:0] mem_r [DEPTH];

   logic [AWIDTH-1:0] wr_ptr_r;
   logic [AWIDTH-1:0] rd_ptr_r;
   logic [AWIDTH:0]   usedw_r;
   logic [DWIDTH-1:0] q_r;
   logic              empty_r;
   logic              full_r;
   logic              almost_full_r;
   logic              almost_empty_r;

   logic              wr_acc_s;
   logic              rd_acc_s;
   logic [AWIDTH:0]   usedw_nxt_s;

   // Request qualification and next occupancy; flags are derived from the next count
   // so that they line up with usedw_o in the same cycle.
   always_comb begin
      wr_acc_s    = wrreq_i & ~full_r;
      rd_acc_s    = rdreq_i & ~empty_r;
      usedw_nxt_s = usedw_r;
      case ({wr_acc_s, rd_acc_s})
         2'b10:   usedw_nxt_s = usedw_r + CNT_ONE;
         2'b01:   usedw_nxt_s = usedw_r - CNT_ONE;
         2'b11:   usedw_nxt_s = usedw_r;
         2'b00:   usedw_nxt_s = usedw_r;
         default: usedw_nxt_s = usedw_r;
      endcase
   end

   // Storage write port, no reset on the array.
   always_ff @(posedge clk_i) begin
      if (wr_acc_s) begin
         mem_r[wr_ptr_r] <= data_i;
      end
   end

   // Pointers, count, registered read data and flags.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_r       <= '0;
         rd_ptr_r       <= '0;
         usedw_r        <= '0;
         q_r            <= '0;
         empty_r        <= 1'b1;
         full_r         <= 1'b0;
         almost_full_r  <= 1'b0;
         almost_empty_r <= 1'b1;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (rd_acc_s) begin
            // Pointer always refers to a word written on an earlier edge, so no bypass.
            q_r      <= mem_r[rd_ptr_r];
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         usedw_r        <= usedw_nxt_s;
         empty_r        <= (usedw_nxt_s == CNT_ZERO);
         full_r         <= (usedw_nxt_s == DEPTH_CNT);
         almost_full_r  <= (usedw_nxt_s >= AF_LVL);
         almost_empty_r <= (usedw_nxt_s < AE_LVL);
      end
   end

   assign q_o            = q_r;
   assign usedw_o        = usedw_r;
   assign empty_o        = empty_r;
   assign full_o         = full_r;
   assign almost_full_o  = almost_full_r;
   assign almost_empty_o = almost_empty_r;

endmodule
